// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding, default width
// and the signed-overflow rule.
package serial_subtractor_pkg;

   localparam int SUB_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Overflow only possible when operand signs differ and the result sign leaves the minuend's.
   function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor; master is the
// upstream/downstream side, slave is the subtractor.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             ovf;
   logic             bout;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, d, ovf, bout
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, d, ovf, bout
   );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell (x - y - bin); purely combinational, no handshake,
// shared by the serial datapath and the combinational subtractor.
module full_subtractor_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell; result valid WIDTH cycles after accept.
// Result held in DONE until out_ready; no new operands accepted until the result is taken.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH,
   parameter int CNT_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_subtractor_if.slave bus
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_borrow;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
   logic             r_bout;

   logic             w_accept;
   logic             w_shift;
   logic             w_last;
   logic             w_diff;
   logic             w_bout_bit;
   logic [WIDTH-1:0] w_res_nxt;

   full_subtractor_bit u_fsb (
      .x    (r_sa[0]),
      .y    (r_sb[0]),
      .bin  (r_borrow),
      .diff (w_diff),
      .bout (w_bout_bit)
   );

   assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
   assign w_shift   = (r_state == ST_SHIFT);
   assign w_last    = w_shift && (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res_nxt = {w_diff, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.in_valid)  w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last)        w_state_nxt = ST_DONE;
         ST_DONE:  if (bus.out_ready) w_state_nxt = ST_IDLE;
         default:                     w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_d      <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
         r_bout   <= 1'b0;
      end else if (w_accept) begin
         r_sa     <= bus.a;
         r_sb     <= bus.b;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_a_msb  <= bus.a[WIDTH-1];
         r_b_msb  <= bus.b[WIDTH-1];
      end else if (w_shift) begin
         r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
         r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
         r_res    <= w_res_nxt;
         r_borrow <= w_bout_bit;
         r_cnt    <= r_cnt + CNT_W'(1);
         // Output regs load only on the final bit so d/ovf/bout stay put between results.
         if (w_last) begin
            r_d    <= w_res_nxt;
            r_bout <= w_bout_bit;
            r_ovf  <= calc_ovf(r_a_msb, r_b_msb, w_diff);
         end
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE) && rst_n;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.d         = r_d;
   assign bus.ovf       = r_ovf;
   assign bus.bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors, backpressure,
// busy-ignore, mid-op reset and a back-to-back stream checked against a small model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_cnt = 0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W), .CNT_W(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
   endtask

   // Arithmetic reference: {ovf, bout, d}
   function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y);
      int sd;
      logic [3:0] dd;
      logic ov, bo;
      sd = int'($signed(x)) - int'($signed(y));
      dd = 4'((int'(x) - int'(y)) & 15);
      bo = (int'(x) < int'(y));
      ov = (sd > 7) || (sd < -8);
      return {ov, bo, dd};
   endfunction

   task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic [3:0] ed, input logic eo, input logic eb);
      int lat;
      wait_idle(tag);
      bus.in_valid = 1'b1;
      bus.a = ta;
      bus.b = tb_v;
      tick();
      bus.in_valid = 1'b0;
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      wait_done(tag, lat);
      chk({tag, "_lat"},  32'(lat), 32'(W));
      chk({tag, "_d"},    32'(bus.d), 32'(ed));
      chk({tag, "_ovf"},  32'(bus.ovf), 32'(eo));
      chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
      tick();
      chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      int t0;
      int acc;
      int prev_acc;
      int hits;
      logic [3:0] x, y;
      logic [5:0] e;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;

      #2;
      chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_d",         32'(bus.d), 32'd0);
      chk("rst_ovf",       32'(bus.ovf), 32'd0);
      chk("rst_bout",      32'(bus.bout), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

      run_op("v7m5",  4'b0111, 4'b0101, 4'b0010, 1'b0, 1'b0);
      run_op("v0m1",  4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1);
      run_op("vDm7",  4'b1101, 4'b0111, 4'b0110, 1'b1, 1'b0);
      run_op("vFm8",  4'b1111, 4'b1000, 4'b0111, 1'b0, 1'b0);
      run_op("v8m1",  4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0);
      run_op("v7m8",  4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1);

      // Backpressure: result must hold while out_ready is low
      bus.out_ready = 1'b0;
      wait_idle("bp");
      bus.in_valid = 1'b1;
      bus.a = 4'b0011;
      bus.b = 4'b0001;
      tick();
      bus.in_valid = 1'b0;
      wait_done("bp", lat);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_vld", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_d",   32'(bus.d), 32'h2);
         chk("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_rel_vld", 32'(bus.out_valid), 32'd0);
      chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);

      // Busy ignore: second operand pair held valid during SHIFT
      wait_idle("busy");
      bus.in_valid = 1'b1;
      bus.a = 4'b1111;
      bus.b = 4'b1111;
      tick();
      bus.a = 4'b0001;
      bus.b = 4'b0000;
      wait_done("busy1", lat);
      chk("busy1_lat",  32'(lat), 32'(W));
      chk("busy1_d",    32'(bus.d), 32'h0);
      chk("busy1_ovf",  32'(bus.ovf), 32'd0);
      chk("busy1_bout", 32'(bus.bout), 32'd0);
      t0 = cyc_cnt;
      tick();
      chk("busy_drop", 32'(bus.out_valid), 32'd0);
      chk("busy_rdy",  32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      wait_done("busy2", lat);
      chk("busy2_d",       32'(bus.d), 32'h1);
      chk("busy2_ovf",     32'(bus.ovf), 32'd0);
      chk("busy2_bout",    32'(bus.bout), 32'd0);
      chk("busy2_spacing", 32'(cyc_cnt - t0), 32'(W + 2));
      tick();

      // Reset two cycles into an operation
      wait_idle("mrst");
      bus.in_valid = 1'b1;
      bus.a = 4'b0110;
      bus.b = 4'b0001;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_vld",  32'(bus.out_valid), 32'd0);
      chk("mrst_rdy",  32'(bus.in_ready), 32'd0);
      chk("mrst_d",    32'(bus.d), 32'h0);
      chk("mrst_ovf",  32'(bus.ovf), 32'd0);
      chk("mrst_bout", 32'(bus.bout), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("mrst_rdy_after", 32'(bus.in_ready), 32'd1);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.out_valid) hits++;
         tick();
      end
      chk("mrst_no_stale", 32'(hits), 32'd0);

      // Back-to-back stream with in_valid held high
      bus.in_valid = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 10; i++) begin
         x = 4'($urandom_range(0, 15));
         y = 4'($urandom_range(0, 15));
         e = model(x, y);
         wait_idle("b2b");
         bus.a = x;
         bus.b = y;
         tick();
         acc = cyc_cnt;
         if (i > 0) chk("b2b_spacing", 32'(acc - prev_acc), 32'(W + 2));
         prev_acc = acc;
         bus.a = 4'($urandom);
         bus.b = 4'($urandom);
         wait_done("b2b", lat);
         chk("b2b_lat",  32'(lat), 32'(W));
         chk("b2b_d",    32'(bus.d), 32'(e[3:0]));
         chk("b2b_bout", 32'(bus.bout), 32'(e[4]));
         chk("b2b_ovf",  32'(bus.ovf), 32'(e[5]));
         tick();
      end
      bus.in_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000, expected finish");
      $fatal(1);
   end

endmodule
